// File: rtl/alu_driver_if.sv
// Bundle of command, ALU and response signals between the ALU driver and its
// environment. The driver uses the slave view: it accepts commands, drives
// the ALU operands and offers responses. The environment uses the master view.
interface alu_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_opcode;
  logic [7:0] alu_c;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [2:0] rsp_op;
  logic       rsp_err;
  logic       busy;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_c, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_data,
           rsp_op, rsp_err, busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_c, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_data,
           rsp_op, rsp_err, busy
  );
endinterface

// File: rtl/alu_driver.sv
// ALU driver: queues commands in a small FIFO, issues them one at a time to a
// downstream ALU with a one-cycle result latency, and returns each result on a
// valid/ready response port. Divide-by-zero is flagged here instead of trusting
// the ALU's result.
module alu_driver #(
  parameter int DEPTH = 4
) (
  input logic        clk,
  input logic        reset,
  alu_driver_if.slave bus
);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int PTR_W   = IDX_W + 1;
  localparam int ENTRY_W = 11;
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [ENTRY_W-1:0] fifo_mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [ENTRY_W-1:0] head_s;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic               capture_s;
  logic               release_s;

  logic [3:0] alu_a_r;
  logic [3:0] alu_b_r;
  logic [2:0] alu_opcode_r;
  logic       rsp_valid_r;
  logic [7:0] rsp_data_r;
  logic [2:0] rsp_op_r;
  logic       rsp_err_r;

  // A divide with a zero divisor must not forward whatever the ALU produced.
  function automatic logic is_div_zero(input logic [2:0] op, input logic [3:0] b);
    return (op == 3'd3) && (b == 4'h0);
  endfunction

  // Pointers carry one extra wrap bit so equal indices can mean full or empty.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                   (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
  // Full blocks a push even when the FSM pops in the same cycle.
  assign push_s  = bus.cmd_valid && !full_s;
  assign head_s  = fifo_mem_r[rd_ptr_r[IDX_W-1:0]];

  assign bus.cmd_ready  = !full_s;
  assign bus.busy       = (state_r != IDLE) || !empty_s;
  assign bus.alu_a      = alu_a_r;
  assign bus.alu_b      = alu_b_r;
  assign bus.alu_opcode = alu_opcode_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_data   = rsp_data_r;
  assign bus.rsp_op     = rsp_op_r;
  assign bus.rsp_err    = rsp_err_r;

  // FIFO storage: write the command at the tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[IDX_W-1:0]] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
    end
  end

  // FIFO pointers: advance independently on push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and per-state strobes for pop, result capture and release.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    capture_s   = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = WAIT;
      end
      WAIT: begin
        capture_s   = 1'b1;
        state_nxt_s = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          release_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // ALU operand registers: loaded from the FIFO head on pop, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a_r      <= 4'h0;
      alu_b_r      <= 4'h0;
      alu_opcode_r <= 3'd0;
    end else if (pop_s) begin
      alu_opcode_r <= head_s[10:8];
      alu_a_r      <= head_s[7:4];
      alu_b_r      <= head_s[3:0];
    end
  end

  // Response registers: capture the ALU result at the end of WAIT, drop valid on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'h00;
      rsp_op_r    <= 3'd0;
      rsp_err_r   <= 1'b0;
    end else if (capture_s) begin
      rsp_valid_r <= 1'b1;
      rsp_op_r    <= alu_opcode_r;
      if (is_div_zero(alu_opcode_r, alu_b_r)) begin
        rsp_data_r <= 8'h00;
        rsp_err_r  <= 1'b1;
      end else begin
        rsp_data_r <= bus.alu_c;
        rsp_err_r  <= 1'b0;
      end
    end else if (release_s) begin
      rsp_valid_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_driver.sv
// Self-checking bench for alu_driver: directed scenarios followed by random
// traffic, scored against an in-order queue of accepted commands.
module tb_alu_driver;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  alu_driver_if bus ();

  alu_driver #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [10:0] exp_q [$];
  int          rec_cyc [$];
  logic [7:0]  rec_dat [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream ALU: result is a register updated one clock after sampling.
  function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] ea;
    logic [7:0] eb;
    ea = {4'h0, a};
    eb = {4'h0, b};
    case (op)
      3'd0: return ea + eb;
      3'd1: return ea - eb;
      3'd2: return ea * eb;
      3'd3: return (b == 4'h0) ? 8'hEE : ea / eb;
      3'd4: return ea & eb;
      3'd5: return ea | eb;
      3'd6: return ea ^ eb;
      default: return {4'h0, ~a};
    endcase
  endfunction

  always @(posedge clk) bus.alu_c <= alu_model(bus.alu_opcode, bus.alu_a, bus.alu_b);

  // Expected response {err, data}: ALU result passed through, except a zero divisor.
  function automatic logic [8:0] ref_rsp(input logic [10:0] cmd);
    if (cmd[10:8] == 3'd3 && cmd[3:0] == 4'h0) return {1'b1, 8'h00};
    return {1'b0, alu_model(cmd[10:8], cmd[7:4], cmd[3:0])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp();
    logic [10:0] e;
    logic [8:0]  r;
    if (exp_q.size() == 0) begin
      chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
    end else begin
      e = exp_q.pop_front();
      r = ref_rsp(e);
      chk("rsp_data", 32'(bus.rsp_data), 32'(r[7:0]));
      chk("rsp_err", 32'(bus.rsp_err), 32'(r[8]));
      chk("rsp_op", 32'(bus.rsp_op), 32'(e[10:8]));
      chk("alu_hold_ops", 32'({bus.alu_opcode, bus.alu_a, bus.alu_b}), 32'(e));
    end
  endtask

  // One clock: score handshakes seen before the edge, then sample at the falling edge.
  task automatic tick();
    logic        push_v;
    logic        fire_v;
    logic        hold_v;
    logic [11:0] snap;
    push_v = bus.cmd_valid && bus.cmd_ready;
    fire_v = bus.rsp_valid && bus.rsp_ready;
    hold_v = bus.rsp_valid && !bus.rsp_ready;
    snap   = {bus.rsp_err, bus.rsp_op, bus.rsp_data};
    if (fire_v) check_rsp();
    if (push_v) exp_q.push_back({bus.cmd_op, bus.cmd_a, bus.cmd_b});
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (hold_v) begin
      chk("rsp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_hold_payload", 32'({bus.rsp_err, bus.rsp_op, bus.rsp_data}), 32'(snap));
    end
    if (bus.rsp_valid) chk("outstanding_at_rsp", 32'(exp_q.size() > 0), 32'd1);
  endtask

  task automatic set_cmd(input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
  endtask

  // Push one command and count sample points until rsp_valid (bounded).
  task automatic push_and_wait(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, output int lat);
    set_cmd(1'b1, op, a, b);
    tick();
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_alu_a"}, 32'(bus.alu_a), 32'd0);
    chk({tag, "_alu_b"}, 32'(bus.alu_b), 32'd0);
    chk({tag, "_alu_opcode"}, 32'(bus.alu_opcode), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    chk({tag, "_rsp_op"}, 32'(bus.rsp_op), 32'd0);
    chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    reset = 1'b1;
    set_cmd(1'b0, 3'd0, 4'h0, 4'h0);
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;

    // Single add into an idle block: first push right after reset release.
    bus.rsp_ready = 1'b1;
    chk("ready_after_release", 32'(bus.cmd_ready), 32'd1);
    push_and_wait(3'd0, 4'd3, 4'd5, lat);
    chk("add_latency", 32'(lat), 32'd4);
    chk("add_data", 32'(bus.rsp_data), 32'h08);
    chk("add_op", 32'(bus.rsp_op), 32'd0);
    chk("add_err", 32'(bus.rsp_err), 32'd0);
    tick();

    // Back-to-back sub then mul: ordered results four cycles apart.
    set_cmd(1'b1, 3'd1, 4'd2, 4'd3);
    tick();
    set_cmd(1'b1, 3'd2, 4'd15, 4'd15);
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (bus.rsp_valid) begin
        rec_cyc.push_back(cyc);
        rec_dat.push_back(bus.rsp_data);
      end
      tick();
    end
    chk("b2b_count", 32'(rec_cyc.size()), 32'd2);
    if (rec_cyc.size() == 2) begin
      chk("b2b_first", 32'(rec_dat[0]), 32'hFF);
      chk("b2b_second", 32'(rec_dat[1]), 32'hE1);
      chk("b2b_spacing", 32'(rec_cyc[1] - rec_cyc[0]), 32'd4);
    end

    // Divide by zero then a normal divide.
    push_and_wait(3'd3, 4'd9, 4'd0, lat);
    chk("div0_data", 32'(bus.rsp_data), 32'h00);
    chk("div0_err", 32'(bus.rsp_err), 32'd1);
    tick();
    push_and_wait(3'd3, 4'd9, 4'd2, lat);
    chk("div_data", 32'(bus.rsp_data), 32'h04);
    chk("div_err", 32'(bus.rsp_err), 32'd0);
    tick();

    // Backpressure: one in flight plus DEPTH queued, then drain in order.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_cmd(1'b1, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom_range(1, 15)));
      tick();
    end
    chk("full_accepted", 32'(exp_q.size()), 32'(DEPTH + 1));
    chk("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("full_busy", 32'(bus.busy), 32'd1);
    chk("full_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("ready_before_pop", 32'(bus.cmd_ready), 32'd0);
    tick();
    chk("ready_after_pop", 32'(bus.cmd_ready), 32'd1);
    drain("full_drain");
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Reset during WAIT with two commands queued.
    set_cmd(1'b1, 3'd6, 4'hA, 4'h5);
    tick();
    set_cmd(1'b1, 3'd0, 4'h7, 4'h1);
    tick();
    set_cmd(1'b1, 3'd2, 4'h3, 4'h3);
    tick();
    bus.cmd_valid = 1'b0;
    chk("wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("wait_alu_a", 32'(bus.alu_a), 32'hA);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (bus.rsp_valid) seen++;
    end
    chk("no_rsp_after_reset", 32'(seen), 32'd0);
    chk("idle_after_reset", 32'(bus.busy), 32'd0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      bus.cmd_valid = ($urandom_range(0, 2) != 0);
      bus.cmd_op    = 3'($urandom_range(0, 7));
      bus.cmd_a     = 4'($urandom);
      bus.cmd_b     = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth in entries; power of 2, minimum 2.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered this cycle.
REQ-005 cmd_ready  output  1  command FIFO can accept; equals not-full.
REQ-006 cmd_a, cmd_b  input  4 each  operands.
REQ-007 cmd_op  input  3  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 not-a.
REQ-008 alu_a, alu_b  output  4 each  registered operands driven to the downstream ALU.
REQ-009 alu_opcode  output  3  registered opcode driven to the ALU.
REQ-010 alu_c  input  8  ALU result; ALU registers it one clock after sampling its inputs.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  consumer accepts response.
REQ-013 rsp_data  output  8  result; rsp_op  output  3  opcode of this result; rsp_err  output  1  divide-by-zero flag.
REQ-014 busy  output  1  high when FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-015 Command push SHALL occur on any edge with cmd_valid and cmd_ready both high; {cmd_op, cmd_a, cmd_b} is written to the FIFO tail.
REQ-016 cmd_ready SHALL be low when the FIFO holds DEPTH entries, even if a pop occurs in the same cycle; no push is accepted while full.
REQ-017 FIFO pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full/empty SHALL be derived from pointer MSB and index comparison.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: if the FIFO is non-empty, pop the head, load alu_a/alu_b/alu_opcode from it, and go to ISSUE; otherwise stay.
REQ-020 ISSUE: hold the alu_* outputs stable for this whole cycle; the ALU samples them at the closing edge; go to WAIT.
REQ-021 WAIT: at the closing edge capture alu_c into rsp_data, alu_opcode into rsp_op, set rsp_valid; go to RESP.
REQ-022 Divide-by-zero: when alu_opcode=3 and alu_b=0, capture rsp_data=8'h00 and rsp_err=1 instead of alu_c; otherwise rsp_err=0.
REQ-023 RESP: rsp_valid, rsp_data, rsp_op, rsp_err held stable until rsp_ready is high; on that edge clear rsp_valid and go to IDLE.
REQ-024 Latency: a command pushed into an empty FIFO with the FSM in IDLE SHALL produce rsp_valid=1 in the 4th cycle after the push edge; back-to-back throughput is one result per 4 cycles with rsp_ready held high.
REQ-025 A push in the same cycle as the IDLE pop SHALL be accepted if the FIFO was not full; the FIFO count stays unchanged.
REQ-026 alu_a, alu_b, alu_opcode SHALL hold their last issued values outside ISSUE/WAIT; rsp_data holds its last value while rsp_valid=0.
REQ-027 rsp_data is passed through unmodified: width extension and wrap-around are the ALU's, not recomputed here.

Reset
REQ-028 Reset SHALL force FSM to IDLE, empty the FIFO (both pointers 0), and drive alu_a=0, alu_b=0, alu_opcode=0, rsp_valid=0, rsp_data=0, rsp_op=0, rsp_err=0, busy=0, cmd_ready=1.
REQ-029 Reset asserted mid-operation SHALL discard the in-flight command and all queued commands; no response is produced for them after reset release.
REQ-030 After reset deassertion, the first push SHALL be accepted on the first rising edge at which cmd_valid is high.

Verification
REQ-031 Push op=0 a=3 b=5 into idle block, rsp_ready=1 -> rsp_valid=1 at 4th cycle after push, rsp_data=8'h08, rsp_op=0, rsp_err=0.
REQ-032 Push op=1 a=2 b=3, then op=2 a=15 b=15 back-to-back -> responses in order: 8'hFF then 8'hE1, 4 cycles apart.
REQ-033 Push op=3 a=9 b=0 -> rsp_data=8'h00, rsp_err=1; following op=3 a=9 b=2 -> rsp_data=8'h04, rsp_err=0.
REQ-034 Hold rsp_ready=0, push continuously with DEPTH=4 -> 1 command in flight, 4 queued, cmd_ready=0; rsp_* stable; release rsp_ready -> all 5 results drain in push order, cmd_ready returns to 1 on the first pop.
REQ-035 Assert reset during WAIT with 2 queued commands -> all outputs at reset values immediately; after release no rsp_valid ever appears until a new push.
